alu_modport: RTL and testbench
==============================

Name: alu_modport

Overview:
- Registered, parameterised arithmetic/logic unit with one-cycle result latency.
- MODE selects the arithmetic or logical command set; CMD selects the operation.
- INP_VALID qualifies which operands are present; CE gates updates.
- The block is the datapath endpoint driven by the ALU driver agent and sampled by the monitor and reference model on the same clock edge.

Parameters:
- WIDTH, 8, operand width in bits.
- CMD_WIDTH, 3, CMD is CMD_WIDTH+1 bits wide (index CMD_WIDTH:0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-low.
- CE  input  1  clock enable; an operation is captured only when 1.
- MODE  input  1  1 = arithmetic set, 0 = logical set.
- CMD  input  CMD_WIDTH+1  operation code.
- INP_VALID  input  2  bit0 = OPA valid, bit1 = OPB valid.
- OPA  input  WIDTH  operand A.
- OPB  input  WIDTH  operand B.
- CIN  input  1  carry-in for the carry-in commands.
- RES  output  WIDTH+2  result, zero-extended.
- ERR  output  1  illegal command, missing operand, or bad rotate amount.
- OFLOW  output  1  subtract borrow.
- COUT  output  1  addition carry-out.
- G  output  1  compare: A greater than B.
- L  output  1  compare: A less than B.
- E  output  1  compare: A equal to B.

Behaviour:
- Reset:
  - Clock and reset are one clock and asynchronous active-low reset, named clk and RST.
  - While RST=0, all outputs are 0 immediately (asynchronous clear).
- Capture and hold:
  - On a rising edge with RST=1 and CE=1, inputs are decoded and all outputs are registered. Latency is 1 cycle.
  - CE=0: all outputs hold their previous values.
  - Every captured operation first clears all flags. Only the flags relevant to that operation are then set.
- Operand requirement:
  - Two-operand commands need INP_VALID=11.
  - A-only commands need bit0=1; B-only commands need bit1=1.
  - If the requirement is not met: ERR=1, RES=0, other flags 0.
- MODE=1 (arithmetic):
  - 0 ADD: RES=A+B; COUT=sum bit WIDTH.
  - 1 SUB: RES=(A-B) mod 2^(WIDTH+1); OFLOW=(A<B).
  - 2 ADD_CIN: RES=A+B+CIN; COUT=sum bit WIDTH.
  - 3 SUB_CIN: RES=(A-B-CIN) mod 2^(WIDTH+1); OFLOW=(A<B+CIN).
  - 4 INC_A: RES=A+1 (A-only).
  - 5 DEC_A: RES=(A-1) mod 2^(WIDTH+1) (A-only).
  - 6 INC_B: RES=B+1 (B-only).
  - 7 DEC_B: RES=(B-1) mod 2^(WIDTH+1) (B-only).
  - 8 CMP: RES=0; exactly one of G, L, E is set.
  - Codes 9–15: ERR=1, RES=0.
- MODE=0 (logical; results occupy RES[WIDTH-1:0], upper bits 0):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT_A (A-only), 7 NOT_B (B-only).
  - 8 SHR1_A, 9 SHL1_A: logical shift by 1, zero fill, bit lost (A-only).
  - 10 SHR1_B, 11 SHL1_B: as above on B (B-only).
  - 12 ROL_A_B, 13 ROR_A_B: rotate A by OPB[$clog2(WIDTH)-1:0].
    - If any higher OPB bit is 1: ERR=1 and the rotated result is still driven on RES.
  - Codes 14–15: ERR=1, RES=0.
- Boundaries:
  - ADD 0xFF+0x01 gives RES=0x100, COUT=1.
  - DEC_A of 0 gives RES=0x1FF (WIDTH+1-bit wrap).
  - CIN is ignored by all commands except 2 and 3.
  - RST asserted mid-operation discards the captured operation; the first edge after release with CE=1 starts fresh.

Decomposition:
- Shared package alu_pkg:
  - Default WIDTH and CMD_WIDTH.
  - Enum of arithmetic command codes and enum of logical command codes.
  - INP_VALID encodings (NONE=00, A=01, B=10, BOTH=11).
- One natural sub-module, alu_comb: purely combinational decode/compute of next RES and flags.
- Top alu_modport holds the output registers, reset and CE gating.

Test Plan:
- RST=0 asynchronously mid-cycle with outputs non-zero → all outputs 0 immediately; outputs stay 0 while held low.
- MODE=1, CMD=0, OPA=0xFF, OPB=0x01, INP_VALID=11, CE=1 → next edge RES=0x100, COUT=1, ERR=0. Then CE=0 with new operands → RES stays 0x100.
- MODE=1, CMD=1, OPA=3, OPB=5 → RES=0x1FE, OFLOW=1. Then CMD=3, OPA=5, OPB=2, CIN=1 → RES=2, OFLOW=0.
- MODE=1, CMD=8, OPA=0x40, OPB=0x40 → E=1, G=0, L=0, RES=0. Then OPA=0x41 → G=1.
- MODE=0, CMD=12, OPA=0x81, OPB=0x01 → RES=0x003, ERR=0. Then OPB=0x10 → ERR=1.
- MODE=0, CMD=0, INP_VALID=01 → ERR=1, RES=0. Then MODE=1, CMD=4, INP_VALID=01, OPA=0xFF → RES=0x100, ERR=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the alu_modport datapath: default sizes, command codes,
// operand-valid encodings and the registered flag bundle.
package alu_pkg;

  localparam int WIDTH_D     = 8;
  localparam int CMD_WIDTH_D = 3;

  typedef enum logic [3:0] {
    A_ADD     = 4'd0,
    A_SUB     = 4'd1,
    A_ADD_CIN = 4'd2,
    A_SUB_CIN = 4'd3,
    A_INC_A   = 4'd4,
    A_DEC_A   = 4'd5,
    A_INC_B   = 4'd6,
    A_DEC_B   = 4'd7,
    A_CMP     = 4'd8
  } arith_cmd_e;

  typedef enum logic [3:0] {
    L_AND    = 4'd0,
    L_NAND   = 4'd1,
    L_OR     = 4'd2,
    L_NOR    = 4'd3,
    L_XOR    = 4'd4,
    L_XNOR   = 4'd5,
    L_NOT_A  = 4'd6,
    L_NOT_B  = 4'd7,
    L_SHR1_A = 4'd8,
    L_SHL1_A = 4'd9,
    L_SHR1_B = 4'd10,
    L_SHL1_B = 4'd11,
    L_ROL    = 4'd12,
    L_ROR    = 4'd13
  } logic_cmd_e;

  typedef enum logic [1:0] {
    IV_NONE = 2'b00,
    IV_A    = 2'b01,
    IV_B    = 2'b10,
    IV_BOTH = 2'b11
  } iv_e;

  typedef struct packed {
    logic err;
    logic oflow;
    logic cout;
    logic g;
    logic l;
    logic e;
  } flags_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational decode and compute of the next ALU result and flags.
// Requires CMD_WIDTH >= 3; any code bit above bit 3 makes the command illegal.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH     = WIDTH_D,
  parameter int CMD_WIDTH = CMD_WIDTH_D
) (
  input  logic                 mode,
  input  logic [CMD_WIDTH:0]   cmd,
  input  logic [1:0]           inp_valid,
  input  logic [WIDTH-1:0]     opa,
  input  logic [WIDTH-1:0]     opb,
  input  logic                 cin,
  output logic [WIDTH+1:0]     res,
  output flags_t               flags
);

  localparam int SW = $clog2(WIDTH);

  logic [3:0]         op;
  logic               op_hi;
  logic [WIDTH:0]     a1;
  logic [WIDTH:0]     b1;
  logic [WIDTH:0]     c1;
  logic [SW-1:0]      amt;
  logic               rot_hi;
  logic [2*WIDTH-1:0] rl;
  logic [2*WIDTH-1:0] rr;

  assign op     = cmd[3:0];
  assign op_hi  = |(cmd >> 4);
  assign a1     = {1'b0, opa};
  assign b1     = {1'b0, opb};
  assign c1     = {{WIDTH{1'b0}}, cin};
  assign amt    = opb[SW-1:0];
  assign rot_hi = |(opb >> SW);
  assign rl     = {opa, opa} << amt;
  assign rr     = {opa, opa} >> amt;

  logic [WIDTH:0] r;
  flags_t         f;
  iv_e            need;
  logic           bad;
  logic           missing;

  always_comb begin
    r    = '0;
    f    = '0;
    need = IV_BOTH;
    bad  = op_hi;
    if (mode) begin
      unique case (op)
        A_ADD: begin
          r      = a1 + b1;
          f.cout = r[WIDTH];
        end
        A_SUB: begin
          r       = a1 - b1;
          f.oflow = opa < opb;
        end
        A_ADD_CIN: begin
          r      = a1 + b1 + c1;
          f.cout = r[WIDTH];
        end
        A_SUB_CIN: begin
          r       = a1 - b1 - c1;
          f.oflow = a1 < (b1 + c1);
        end
        A_INC_A: begin
          r    = a1 + 1'b1;
          need = IV_A;
        end
        A_DEC_A: begin
          r    = a1 - 1'b1;
          need = IV_A;
        end
        A_INC_B: begin
          r    = b1 + 1'b1;
          need = IV_B;
        end
        A_DEC_B: begin
          r    = b1 - 1'b1;
          need = IV_B;
        end
        A_CMP: begin
          f.g = opa > opb;
          f.l = opa < opb;
          f.e = opa == opb;
        end
        default: bad = 1'b1;
      endcase
    end else begin
      unique case (op)
        L_AND:  r = {1'b0, opa & opb};
        L_NAND: r = {1'b0, ~(opa & opb)};
        L_OR:   r = {1'b0, opa | opb};
        L_NOR:  r = {1'b0, ~(opa | opb)};
        L_XOR:  r = {1'b0, opa ^ opb};
        L_XNOR: r = {1'b0, ~(opa ^ opb)};
        L_NOT_A: begin
          r    = {1'b0, ~opa};
          need = IV_A;
        end
        L_NOT_B: begin
          r    = {1'b0, ~opb};
          need = IV_B;
        end
        L_SHR1_A: begin
          r    = {2'b0, opa[WIDTH-1:1]};
          need = IV_A;
        end
        L_SHL1_A: begin
          r    = {1'b0, opa[WIDTH-2:0], 1'b0};
          need = IV_A;
        end
        L_SHR1_B: begin
          r    = {2'b0, opb[WIDTH-1:1]};
          need = IV_B;
        end
        L_SHL1_B: begin
          r    = {1'b0, opb[WIDTH-2:0], 1'b0};
          need = IV_B;
        end
        // Out-of-range amount flags ERR but still delivers the rotation.
        L_ROL: begin
          r     = {1'b0, rl[2*WIDTH-1:WIDTH]};
          f.err = rot_hi;
        end
        L_ROR: begin
          r     = {1'b0, rr[WIDTH-1:0]};
          f.err = rot_hi;
        end
        default: bad = 1'b1;
      endcase
    end
  end

  assign missing = (inp_valid & need) != need;

  always_comb begin
    res   = '0;
    flags = '0;
    unique case (1'b1)
      bad || missing: flags.err = 1'b1;
      default: begin
        res   = {1'b0, r};
        flags = f;
      end
    endcase
  end

endmodule

// File: rtl/alu_modport.sv
// Registered ALU top: output registers with async active-low clear and
// clock-enable gating around the combinational compute block.
module alu_modport
  import alu_pkg::*;
#(
  parameter int WIDTH     = WIDTH_D,
  parameter int CMD_WIDTH = CMD_WIDTH_D
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               CE,
  input  logic               MODE,
  input  logic [CMD_WIDTH:0] CMD,
  input  logic [1:0]         INP_VALID,
  input  logic [WIDTH-1:0]   OPA,
  input  logic [WIDTH-1:0]   OPB,
  input  logic               CIN,
  output logic [WIDTH+1:0]   RES,
  output logic               ERR,
  output logic               OFLOW,
  output logic               COUT,
  output logic               G,
  output logic               L,
  output logic               E
);

  logic [WIDTH+1:0] res_n;
  flags_t           fl_n;
  flags_t           fl_q;

  alu_comb #(
    .WIDTH     (WIDTH),
    .CMD_WIDTH (CMD_WIDTH)
  ) u_comb (
    .mode      (MODE),
    .cmd       (CMD),
    .inp_valid (INP_VALID),
    .opa       (OPA),
    .opb       (OPB),
    .cin       (CIN),
    .res       (res_n),
    .flags     (fl_n)
  );

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      RES  <= '0;
      fl_q <= '0;
    end else if (CE) begin
      RES  <= res_n;
      fl_q <= fl_n;
    end
  end

  assign ERR   = fl_q.err;
  assign OFLOW = fl_q.oflow;
  assign COUT  = fl_q.cout;
  assign G     = fl_q.g;
  assign L     = fl_q.l;
  assign E     = fl_q.e;

endmodule

// File: tb/tb_alu_modport.sv
// Randomised self-checking bench for alu_modport against an arithmetic
// reference model of the command set.
module tb_alu_modport;

  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          RST;
  logic          CE;
  logic          MODE;
  logic [CW:0]   CMD;
  logic [1:0]    INP_VALID;
  logic [W-1:0]  OPA;
  logic [W-1:0]  OPB;
  logic          CIN;
  logic [W+1:0]  RES;
  logic          ERR, OFLOW, COUT, G, L, E;

  int vecs = 0;
  int errs = 0;
  logic [15:0] want_q = '0;

  alu_modport #(.WIDTH(W), .CMD_WIDTH(CW)) dut (
    .clk(clk), .RST(RST), .CE(CE), .MODE(MODE), .CMD(CMD),
    .INP_VALID(INP_VALID), .OPA(OPA), .OPB(OPB), .CIN(CIN),
    .RES(RES), .ERR(ERR), .OFLOW(OFLOW), .COUT(COUT),
    .G(G), .L(L), .E(E)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] obs();
    return {RES, ERR, OFLOW, COUT, G, L, E};
  endfunction

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got res=%h flags(eocgle)=%b want res=%h flags=%b",
               tag, got[15:6], got[5:0], want[15:6], want[5:0]);
    end
  endtask

  function automatic logic [15:0] model(input int m, input int c,
                                        input int iv, input int a,
                                        input int b, input int ci);
    int res, amt;
    bit er, of, co, g, l, e, ok_a, ok_b, need_a, need_b;
    res = 0; er = 0; of = 0; co = 0; g = 0; l = 0; e = 0;
    ok_a = iv[0]; ok_b = iv[1];
    need_a = 1; need_b = 1;
    if (m == 1) begin
      if (c inside {4, 5}) need_b = 0;
      if (c inside {6, 7}) need_a = 0;
      case (c)
        0: res = a + b;
        1: res = (a - b) & 511;
        2: res = a + b + ci;
        3: res = (a - b - ci) & 511;
        4: res = a + 1;
        5: res = (a - 1) & 511;
        6: res = b + 1;
        7: res = (b - 1) & 511;
        8: begin g = a > b; l = a < b; e = a == b; end
        default: er = 1;
      endcase
      if (c == 0 || c == 2) co = res >= 256;
      if (c == 1) of = a < b;
      if (c == 3) of = a < b + ci;
    end else begin
      if (c inside {6, 8, 9}) need_b = 0;
      if (c inside {7, 10, 11}) need_a = 0;
      amt = b % 8;
      case (c)
        0: res = a & b;
        1: res = ~(a & b) & 255;
        2: res = a | b;
        3: res = ~(a | b) & 255;
        4: res = a ^ b;
        5: res = ~(a ^ b) & 255;
        6: res = ~a & 255;
        7: res = ~b & 255;
        8: res = a / 2;
        9: res = (a * 2) % 256;
        10: res = b / 2;
        11: res = (b * 2) % 256;
        12: begin res = ((a << amt) | (a >> (8 - amt))) & 255; er = b >= 8; end
        13: begin res = ((a >> amt) | (a << (8 - amt))) & 255; er = b >= 8; end
        default: er = 1;
      endcase
    end
    if (er && res == 0 && !(m == 0 && c inside {12, 13})) begin
      return 16'h0020;
    end
    if ((need_a && !ok_a) || (need_b && !ok_b)) return 16'h0020;
    return {10'(res), er, of, co, g, l, e};
  endfunction

  task automatic op(input string tag, input bit ce, input int m,
                    input int c, input int iv, input int a, input int b,
                    input int ci);
    @(negedge clk);
    CE = ce; MODE = m[0]; CMD = 4'(c); INP_VALID = 2'(iv);
    OPA = 8'(a); OPB = 8'(b); CIN = ci[0];
    @(posedge clk);
    #1;
    if (ce) want_q = model(m, c, iv, a, b, ci);
    check(tag, obs(), want_q);
  endtask

  initial begin
    RST = 1'b0; CE = 1'b1; MODE = 1'b1; CMD = '0; INP_VALID = 2'b11;
    OPA = 8'hFF; OPB = 8'hFF; CIN = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("reset_state", obs(), 16'h0000);
    @(negedge clk) RST = 1'b1;

    op("add_ff_01", 1, 1, 0, 3, 8'hFF, 8'h01, 0);
    check("add_ff_01_abs", obs(), {10'h100, 6'b001000});
    op("ce0_hold", 0, 1, 1, 3, 8'h12, 8'h34, 1);
    check("ce0_hold_abs", obs(), {10'h100, 6'b001000});

    // Asynchronous clear between edges while outputs are non-zero.
    @(negedge clk); #2 RST = 1'b0;
    #1 check("async_clear", obs(), 16'h0000);
    repeat (2) @(posedge clk);
    #1 check("held_low", obs(), 16'h0000);
    want_q = '0;
    @(negedge clk) RST = 1'b1;

    op("sub_borrow", 1, 1, 1, 3, 3, 5, 0);
    check("sub_borrow_abs", obs(), {10'h1FE, 6'b010000});
    op("subc", 1, 1, 3, 3, 5, 2, 1);
    op("cmp_eq", 1, 1, 8, 3, 8'h40, 8'h40, 1);
    op("cmp_gt", 1, 1, 8, 3, 8'h41, 8'h40, 0);
    op("rol_ok", 1, 0, 12, 3, 8'h81, 8'h01, 0);
    check("rol_ok_abs", obs(), {10'h003, 6'b000000});
    op("rol_bad_amt", 1, 0, 12, 3, 8'h81, 8'h10, 0);
    op("and_missing_b", 1, 0, 0, 1, 8'hAA, 8'h55, 0);
    op("inc_a_ff", 1, 1, 4, 1, 8'hFF, 8'h00, 0);
    op("dec_a_zero", 1, 1, 5, 1, 8'h00, 8'h00, 1);
    op("add_cin_ignored", 1, 1, 0, 3, 8'h10, 8'h20, 1);
    op("arith_illegal", 1, 1, 9, 3, 8'h10, 8'h20, 0);
    op("logic_illegal", 1, 0, 15, 3, 8'h10, 8'h20, 0);
    op("inc_b_missing", 1, 1, 6, 1, 8'h10, 8'h20, 0);

    for (int i = 0; i < 400; i++) begin
      op("random", ($urandom_range(0, 4) != 0), $urandom_range(0, 1),
         $urandom_range(0, 15), $urandom_range(0, 3),
         $urandom_range(0, 255),
         ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                     : $urandom_range(0, 7),
         $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
